// File: rtl/hazard_unit_if.sv
// Decode/EX/ME hazard inputs and latch control outputs exchanged between the pipeline and the hazard unit.
interface hazard_unit_if;
  logic        ihit;
  logic        dhit;
  logic [31:0] instru_de;
  logic        usesRt_de;
  logic [4:0]  regDst_ex;
  logic        regWr_ex;
  logic        dREN_ex;
  logic        dREN_me;
  logic        dWEN_me;
  logic        redirect_ex;
  logic        halt_me;

  logic        pc_en;
  logic        fd_en;
  logic        fd_flush;
  logic        de_en;
  logic        de_flush;
  logic        em_en;
  logic        em_flush;
  logic        mw_en;
  logic        mw_flush;
  logic        halt;

  modport master (
    output ihit, dhit, instru_de, usesRt_de, regDst_ex, regWr_ex,
           dREN_ex, dREN_me, dWEN_me, redirect_ex, halt_me,
    input  pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush,
           mw_en, mw_flush, halt
  );

  modport slave (
    input  ihit, dhit, instru_de, usesRt_de, regDst_ex, regWr_ex,
           dREN_ex, dREN_me, dWEN_me, redirect_ex, halt_me,
    output pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush,
           mw_en, mw_flush, halt
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/PC-enable control for the 5-stage core with saturating stall/flush counters.
// Controls are same-cycle combinational; only RUN/MEM/HALT state and counters are registered.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  hazard_unit_if.slave     hu,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MEM  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       memwait;
  logic       load_use;
  logic       stall_evt;
  logic       flush_evt;
  logic       unused_instr_bits;

  assign rs                = hu.instru_de[25:21];
  assign rt                = hu.instru_de[20:16];
  assign unused_instr_bits = ^{hu.instru_de[31:26], hu.instru_de[15:0]};

  assign memwait  = (hu.dREN_me | hu.dWEN_me) & ~hu.dhit;
  // r0 is hardwired zero, so a load targeting it never produces a dependency
  assign load_use = hu.dREN_ex & hu.regWr_ex & (hu.regDst_ex != 5'd0) &
                    ((hu.regDst_ex == rs) | (hu.usesRt_de & (hu.regDst_ex == rt)));

  always_comb begin
    hu.pc_en    = 1'b0;
    hu.fd_en    = 1'b0;
    hu.fd_flush = 1'b0;
    hu.de_en    = 1'b0;
    hu.de_flush = 1'b0;
    hu.em_en    = 1'b0;
    hu.em_flush = 1'b0;
    hu.mw_en    = 1'b0;
    hu.mw_flush = 1'b0;
    flush_evt   = 1'b0;
    if (nRST && (state != HALT)) begin
      if (memwait) begin
        hu.mw_flush = 1'b1;
      end else if (hu.redirect_ex) begin
        hu.pc_en    = 1'b1;
        hu.fd_flush = 1'b1;
        hu.de_flush = 1'b1;
        hu.em_en    = 1'b1;
        hu.mw_en    = 1'b1;
        flush_evt   = 1'b1;
      end else if (load_use) begin
        hu.de_flush = 1'b1;
        hu.em_en    = 1'b1;
        hu.mw_en    = 1'b1;
      end else if (!hu.ihit) begin
        hu.fd_flush = 1'b1;
        hu.de_en    = 1'b1;
        hu.em_en    = 1'b1;
        hu.mw_en    = 1'b1;
      end else begin
        hu.pc_en    = 1'b1;
        hu.fd_en    = 1'b1;
        hu.de_en    = 1'b1;
        hu.em_en    = 1'b1;
        hu.mw_en    = 1'b1;
      end
    end
  end

  assign hu.halt   = (state == HALT);
  assign stall_evt = nRST & (state != HALT) & ~hu.pc_en;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN, MEM: begin
          // a halt behind an outstanding data access waits for that access to finish
          if (hu.halt_me && !memwait) state <= HALT;
          else if (memwait)           state <= MEM;
          else                        state <= RUN;
        end
        default: state <= HALT;
      endcase
      if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
